// File: rtl/comparator_sync_multi.sv
// Multi-channel comparator conditioner: per-channel synchronizer, stability filter,
// rise/fall pulses and a ramp_count capture register with valid/ack handshake and overrun flag.
module comparator_sync_multi #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         vcompare_raw,
  input  logic [N_CH-1:0]         edge_sel,
  input  logic [CNT_W-1:0]        ramp_count,
  input  logic [N_CH-1:0]         cap_ack,
  output logic [N_CH-1:0]         vcompare_filt,
  output logic [N_CH-1:0]         rise_pulse,
  output logic [N_CH-1:0]         fall_pulse,
  output logic [N_CH-1:0]         cap_valid,
  output logic [N_CH*CNT_W-1:0]   cap_value,
  output logic [N_CH-1:0]         cap_overrun
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   filt_q, filt_d;
      logic                   rise_q, fall_q;
      logic                   valid_q, valid_d;
      logic                   ovr_q, ovr_d;
      logic [CNT_W-1:0]       value_q, value_d;
      logic                   sync_bit, commit, cap_event;

      assign sync_bit = sync_q[SYNC_STAGES-1];

      always_comb begin
        commit    = 1'b0;
        cnt_d     = '0;
        filt_d    = filt_q;
        if (sync_bit != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
            filt_d = sync_bit;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A commit to 1 is a rising edge, to 0 a falling edge; edge_sel picks which one captures.
        cap_event = commit & (sync_bit ^ edge_sel[gi]);

        valid_d = valid_q;
        ovr_d   = ovr_q;
        value_d = value_q;
        if (cap_event) begin
          if (!valid_q || cap_ack[gi]) begin
            value_d = ramp_count;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
          end else begin
            ovr_d   = 1'b1;
          end
        end else if (cap_ack[gi] && valid_q) begin
          valid_d = 1'b0;
          ovr_d   = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q  <= '0;
          cnt_q   <= '0;
          filt_q  <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          valid_q <= 1'b0;
          ovr_q   <= 1'b0;
          value_q <= '0;
        end else begin
          sync_q  <= {sync_q[SYNC_STAGES-2:0], vcompare_raw[gi]};
          cnt_q   <= cnt_d;
          filt_q  <= filt_d;
          rise_q  <= commit & sync_bit;
          fall_q  <= commit & ~sync_bit;
          valid_q <= valid_d;
          ovr_q   <= ovr_d;
          value_q <= value_d;
        end
      end

      assign vcompare_filt[gi]              = filt_q;
      assign rise_pulse[gi]                 = rise_q;
      assign fall_pulse[gi]                 = fall_q;
      assign cap_valid[gi]                  = valid_q;
      assign cap_overrun[gi]                = ovr_q;
      assign cap_value[gi*CNT_W +: CNT_W]   = value_q;
    end
  endgenerate

endmodule

// File: tb/tb_comparator_sync_multi.sv
// Randomized scoreboard bench for comparator_sync_multi: a window-based reference model
// predicts every output each cycle; a monitor pops and compares on the falling edge.
module tb_comparator_sync_multi;
  localparam int N_CH = 4;
  localparam int S    = 2;
  localparam int F    = 4;
  localparam int W    = 8;
  localparam int NCYC = 4000;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_CH-1:0]     vcompare_raw, edge_sel, cap_ack;
  logic [W-1:0]        ramp_count;
  logic [N_CH-1:0]     vcompare_filt, rise_pulse, fall_pulse, cap_valid, cap_overrun;
  logic [N_CH*W-1:0]   cap_value;

  always #5 clk = ~clk;

  comparator_sync_multi #(.N_CH(N_CH), .SYNC_STAGES(S), .FILTER_CYCLES(F), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .vcompare_raw(vcompare_raw), .edge_sel(edge_sel),
    .ramp_count(ramp_count), .cap_ack(cap_ack), .vcompare_filt(vcompare_filt),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .cap_valid(cap_valid),
    .cap_value(cap_value), .cap_overrun(cap_overrun)
  );

  typedef struct {
    int                cyc;
    logic [N_CH-1:0]   filt, rise, fall, valid, ovr;
    logic [N_CH*W-1:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: raw delay line, last F filter-visible samples, outputs.
  bit              dl   [N_CH][S];
  bit              hist [N_CH][F];
  int              hist_n [N_CH];
  bit [N_CH-1:0]   m_filt, m_rise, m_fall, m_valid, m_ovr;
  bit [W-1:0]      m_val [N_CH];

  task automatic model_step(input int cyc);
    exp_t e;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (reset) begin
        for (int j = 0; j < S; j++) dl[ch][j] = 1'b0;
        hist_n[ch] = 0;
        m_filt[ch] = 1'b0; m_rise[ch] = 1'b0; m_fall[ch] = 1'b0;
        m_valid[ch] = 1'b0; m_ovr[ch] = 1'b0; m_val[ch] = '0;
      end else begin
        bit seen, commit, ev;
        seen = dl[ch][S-1];
        for (int j = S-1; j > 0; j--) dl[ch][j] = dl[ch][j-1];
        dl[ch][0] = vcompare_raw[ch];
        for (int j = F-1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = seen;
        if (hist_n[ch] < F) hist_n[ch]++;
        // Level commits once the last F visible samples all disagree with the filtered level.
        commit = (hist_n[ch] >= F);
        for (int j = 0; j < F; j++) if (hist[ch][j] == m_filt[ch]) commit = 1'b0;
        m_rise[ch] = commit && seen;
        m_fall[ch] = commit && !seen;
        if (commit) m_filt[ch] = seen;
        ev = (m_rise[ch] && !edge_sel[ch]) || (m_fall[ch] && edge_sel[ch]);
        if (ev && (!m_valid[ch] || cap_ack[ch])) begin
          m_val[ch] = ramp_count; m_valid[ch] = 1'b1; m_ovr[ch] = 1'b0;
        end else if (ev) begin
          m_ovr[ch] = 1'b1;
        end else if (cap_ack[ch] && m_valid[ch]) begin
          m_valid[ch] = 1'b0; m_ovr[ch] = 1'b0;
        end
      end
    end
    e.cyc = cyc;
    e.filt = m_filt; e.rise = m_rise; e.fall = m_fall; e.valid = m_valid; e.ovr = m_ovr;
    for (int ch = 0; ch < N_CH; ch++) e.value[ch*W +: W] = m_val[ch];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int cyc, input logic [N_CH*W-1:0] act,
                     input logic [N_CH*W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a full response to compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("filt",    e.cyc, (N_CH*W)'(vcompare_filt), (N_CH*W)'(e.filt));
        chk("rise",    e.cyc, (N_CH*W)'(rise_pulse),    (N_CH*W)'(e.rise));
        chk("fall",    e.cyc, (N_CH*W)'(fall_pulse),    (N_CH*W)'(e.fall));
        chk("valid",   e.cyc, (N_CH*W)'(cap_valid),     (N_CH*W)'(e.valid));
        chk("overrun", e.cyc, (N_CH*W)'(cap_overrun),   (N_CH*W)'(e.ovr));
        chk("value",   e.cyc, cap_value,                e.value);
        $display("cyc=%0d filt=%b rise=%b fall=%b valid=%b ovr=%b value=%h",
                 e.cyc, vcompare_filt, rise_pulse, fall_pulse, cap_valid, cap_overrun, cap_value);
      end
    end
  end

  initial begin
    int tog_div, ack_div;
    reset = 1'b1; vcompare_raw = '0; edge_sel = '0; cap_ack = '0; ramp_count = '0;
    tog_div = 2; ack_div = 4;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Vary glitchiness and ack rate in segments to reach short pulses, commits and overruns.
      if (cyc % 250 == 0) begin
        tog_div = $urandom_range(2, 12);
        ack_div = ($urandom_range(0, 1) != 0) ? 3 : 40;
      end
      reset = (cyc < 2) || ($urandom_range(0, 499) == 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, tog_div - 1) == 0) vcompare_raw[ch] = ~vcompare_raw[ch];
        if ($urandom_range(0, 59) == 0) edge_sel[ch] = ~edge_sel[ch];
        cap_ack[ch] = ($urandom_range(0, ack_div - 1) == 0);
      end
      ramp_count = W'($urandom);
      @(posedge clk);
      model_step(cyc);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
